nios_cpu_debug_ocimem_ctrl: RTL
===============================

# nios_cpu_debug_ocimem_ctrl

Sequencer/arbiter for the Nios II on-chip debug memory (OCI RAM, 256 x 32). Turns the debug slave's sysclk-domain command strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`, `jdo`) into single-word RAM accesses. It shares the RAM with the CPU's debug_mem_slave port. It returns read data and status to the debug slave via `MonDReg`, `monitor_ready` and `monitor_error`.

## Interface
- `ADDR_W`, 8, OCI RAM word-address width
- `clk`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `jdo`  in  38  debug slave shift data; [ADDR_W+1:2] address, [34:3] write data, [36] read-after-load flag
- `take_action_ocimem_a`  in  1  load address from jdo; also read if jdo[36]=1
- `take_action_ocimem_b`  in  1  write jdo[34:3] at current address
- `take_no_action_ocimem_a`  in  1  read at current address
- `debugack`  in  1  CPU in debug mode; JTAG accesses legal only when 1
- `cpu_req`, `cpu_we`  in  1 each  CPU access request/write; held until accepted
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  32  CPU write data
- `cpu_rdata`  out  32  CPU read data; valid while cpu_waitrequest=0 on a read
- `cpu_waitrequest`  out  1  stall
- `ram_en`, `ram_we`  out  1 each  RAM strobe/write enable
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  32  RAM write data
- `ram_rdata`  in  32  RAM read data, 1-cycle latency
- `MonDReg`  out  32  last JTAG read result
- `monitor_ready`  out  1  JTAG command complete
- `monitor_error`  out  1  sticky JTAG error

## Operation
- Reset values: state IDLE, address 0, no pending command, `MonDReg`=0, `monitor_ready`=0, `monitor_error`=0, `cpu_waitrequest`=1, all ram_* =0.
- Strobe latch: any strobe sets a one-entry pending command (read or write) and clears `monitor_ready`.
  - A strobe while a command is already pending is dropped and sets `monitor_error`.
  - A strobe with `debugack`=0 is dropped and sets `monitor_error`.
  - Address-only load (`ocimem_a` with jdo[36]=0) completes immediately: `monitor_ready`=1 next cycle.
- `monitor_error` clears on an accepted `take_action_ocimem_a` only.
- FSM states: IDLE, JGRANT, JRESP, CGRANT, CRESP.
  - IDLE: pending JTAG command goes to JGRANT, else `cpu_req` goes to CGRANT. Tie-break: if the last grant was JTAG and `cpu_req`=1, CPU wins (alternating fairness).
  - JGRANT (1 cycle): `ram_en`=1, ram_we per command, ram_addr = JTAG address. Then JRESP.
  - JRESP: reads capture `ram_rdata` into `MonDReg`. Set `monitor_ready`, clear pending, go to IDLE.
  - CGRANT (1 cycle): `ram_en`=1 with CPU address, data and we. Then CRESP.
  - CRESP: `cpu_waitrequest`=0, `cpu_rdata`=`ram_rdata`. Go to IDLE.
- No preemption; a granted access always completes.
- Address arithmetic: ADDR_W-bit modulo; 2^ADDR_W-1 wraps to 0.

## Timing
- JTAG strobe sampled at edge t: pending at t+1, JGRANT earliest cycle t+1 to t+2, `MonDReg`/`monitor_ready` valid from the edge ending JRESP. Uncontended: strobe at t, `monitor_ready`=1 at t+3.
- CPU: `cpu_req` seen in IDLE at cycle c gives CGRANT at c+1 and `cpu_waitrequest`=0 for exactly one cycle at c+2.
- Worst-case wait for either side is one foreign access (2 cycles) plus own access.
- Asynchronous reset mid-operation aborts the access: pending dropped, `cpu_waitrequest` forced to 1 immediately.

## Configuration
- `OCIMEM_AUTOINC_EN` defined: the JTAG address increments by 1 (wrapping) after each completed JTAG read or write.
- Not defined: the address holds; only `take_action_ocimem_a` changes it.
- CPU addressing is unaffected either way.

## Structure
- Shared package `nios_dbg_pkg`:
  - state enum
  - JTAG command enum (NONE, LOAD, READ, WRITE)
  - jdo field position constants (`JDO_ADDR_LSB`=2, `JDO_WDATA_LSB`=3, `JDO_RDFLAG_BIT`=36)
- One sub-module, `nios_dbg_jtag_cmd_latch`: strobe decode, debugack check, pending/drop/error logic, address register. The FSM/arbiter stays in the top.

## Test plan
- Load addr 0x10 with jdo[36]=1, RAM[0x10]=0xDEADBEEF: `MonDReg`=0xDEADBEEF, `monitor_ready`=1 three cycles after the strobe.
- Write 0x12345678 via `ocimem_b` at 0xFF with AUTOINC on, then read via `take_no_action_ocimem_a`: RAM[0xFF]=0x12345678 and the read targets address 0x00 (wrap). With AUTOINC off, the read returns 0x12345678.
- `cpu_req` and JTAG strobe arriving in the same cycle twice in a row: grants alternate JTAG, CPU, JTAG, CPU; each CPU read sees `cpu_waitrequest` low for exactly one cycle with correct data.
- Strobe with `debugack`=0, and a second strobe while one is pending: both dropped, no `ram_en`, `monitor_error`=1; it clears on the next accepted `ocimem_a`.
- Assert `reset_n` low during JGRANT: all outputs return to reset values asynchronously. After release, no stale RAM access and `monitor_ready`=0.

Source files
------------

// File: rtl/nios_dbg_pkg.sv
// ---------------------------------------------------------------------------
// nios_dbg_pkg
// Shared types and constants for the Nios II OCI debug-memory sequencer.
//   - ocimem_state_e : arbiter/sequencer FSM states
//   - jtag_cmd_e     : decoded JTAG command held in the one-entry latch
//   - jdo field positions used to slice the debug slave shift register
// ---------------------------------------------------------------------------
package nios_dbg_pkg;

  localparam int JDO_W  = 38;
  localparam int DATA_W = 32;

  // Bit positions inside jdo
  localparam int JDO_ADDR_LSB   = 2;
  localparam int JDO_WDATA_LSB  = 3;
  localparam int JDO_RDFLAG_BIT = 36;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_JGRANT = 3'd1,
    ST_JRESP  = 3'd2,
    ST_CGRANT = 3'd3,
    ST_CRESP  = 3'd4
  } ocimem_state_e;

  // LOAD is an address-only load: it completes at the strobe and never
  // becomes a pending command.
  typedef enum logic [1:0] {
    JCMD_NONE  = 2'd0,
    JCMD_LOAD  = 2'd1,
    JCMD_READ  = 2'd2,
    JCMD_WRITE = 2'd3
  } jtag_cmd_e;

endpackage

// File: rtl/nios_dbg_jtag_cmd_latch.sv
// ---------------------------------------------------------------------------
// nios_dbg_jtag_cmd_latch
// Decodes the debug slave's command strobes into a one-entry pending JTAG
// command, owns the JTAG address / write-data registers and the
// monitor_ready / monitor_error status flags.
//
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   jdo                     : debug slave shift data (address, data, rd flag)
//   take_action_ocimem_a    : load address (and read when jdo[36]=1)
//   take_action_ocimem_b    : write jdo write-data field at current address
//   take_no_action_ocimem_a : read at current address
//   debugack                : CPU in debug mode; strobes are legal only then
//   cmd_done                : one-cycle pulse from the sequencer when the
//                             pending command's response cycle ends
//   pending                 : a READ/WRITE command waits for / holds the RAM
//   cmd                     : the pending command (JCMD_NONE when idle)
//   addr, wdata             : JTAG word address and write data
//   monitor_ready           : JTAG command complete
//   monitor_error           : sticky error (dropped strobe)
//
// Configuration macro: OCIMEM_AUTOINC_EN -- when defined the JTAG address
// advances by one (modulo 2^ADDR_W) after every completed read or write.
// ---------------------------------------------------------------------------
module nios_dbg_jtag_cmd_latch
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic              cmd_done,
  output logic              pending,
  output jtag_cmd_e         cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              monitor_ready,
  output logic              monitor_error
);

  logic      any_strobe;
  logic      accept;
  jtag_cmd_e strobe_cmd;
  logic      unused_jdo;

  // jdo bits outside the address / data / flag fields carry nothing here
  assign unused_jdo = ^{jdo[1:0], jdo[35], jdo[37]};

  // Simultaneous strobes resolve to a single command: a, then b, then read.
  always_comb begin
    strobe_cmd = JCMD_NONE;
    if (take_action_ocimem_a) begin
      strobe_cmd = jdo[JDO_RDFLAG_BIT] ? JCMD_READ : JCMD_LOAD;
    end else if (take_action_ocimem_b) begin
      strobe_cmd = JCMD_WRITE;
    end else if (take_no_action_ocimem_a) begin
      strobe_cmd = JCMD_READ;
    end
  end

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                      take_no_action_ocimem_a;
  // Only one command may be outstanding and the CPU must be halted.
  assign accept     = any_strobe & debugack & ~pending;
  assign pending    = (cmd != JCMD_NONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd           <= JCMD_NONE;
      addr          <= '0;
      wdata         <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (any_strobe && !accept) begin
        monitor_error <= 1'b1;
      end

      if (accept) begin
        if (take_action_ocimem_a) begin
          addr          <= jdo[JDO_ADDR_LSB +: ADDR_W];
          monitor_error <= 1'b0;
        end
        if (strobe_cmd == JCMD_WRITE) begin
          wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
        end
        if (strobe_cmd == JCMD_LOAD) begin
          // Address-only load has nothing to do on the RAM.
          monitor_ready <= 1'b1;
        end else begin
          cmd           <= strobe_cmd;
          monitor_ready <= 1'b0;
        end
      end else if (cmd_done) begin
        // accept requires !pending and cmd_done only fires while pending,
        // so the two branches never compete.
        cmd           <= JCMD_NONE;
        monitor_ready <= 1'b1;
`ifdef OCIMEM_AUTOINC_EN
        addr          <= addr + ADDR_W'(1);
`else
        addr          <= addr;
`endif
      end
    end
  end

endmodule

// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios_cpu_debug_ocimem_ctrl
// Sequencer/arbiter for the Nios II on-chip debug memory (OCI RAM). Shares a
// single-port RAM (1-cycle read latency) between JTAG debug commands and the
// CPU's debug_mem_slave port, alternating grants when both contend.
//
// Ports
//   clk, reset_n             : clock, asynchronous active-low reset
//   jdo, take_action_ocimem_a/b, take_no_action_ocimem_a, debugack
//                            : JTAG command strobes (see command latch)
//   cpu_req, cpu_we, cpu_addr, cpu_wdata
//                            : CPU access request
//   cpu_rdata, cpu_waitrequest : CPU response / stall
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata : OCI RAM port
//   MonDReg                  : last JTAG read result
//   monitor_ready            : JTAG command complete
//   monitor_error            : sticky JTAG error
//
// CPU handshake: the CPU holds cpu_req/cpu_we/cpu_addr/cpu_wdata stable
// while cpu_waitrequest=1; the access is accepted at the rising edge that
// ends the single cycle with cpu_waitrequest=0, during which cpu_rdata holds
// read data. The CPU changes or drops its request only after that edge.
//
// Configuration macro: OCIMEM_AUTOINC_EN (JTAG address auto-increment, see
// nios_dbg_jtag_cmd_latch).
// ---------------------------------------------------------------------------
module nios_cpu_debug_ocimem_ctrl
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              debugack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_waitrequest,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_e     state, state_nx;
  logic              last_jtag, last_jtag_nx;
  logic              j_pending;
  jtag_cmd_e         j_cmd;
  logic [ADDR_W-1:0] j_addr;
  logic [DATA_W-1:0] j_wdata;
  logic              cmd_done;

  nios_dbg_jtag_cmd_latch #(
    .ADDR_W (ADDR_W)
  ) u_cmd_latch (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .debugack                (debugack),
    .cmd_done                (cmd_done),
    .pending                 (j_pending),
    .cmd                     (j_cmd),
    .addr                    (j_addr),
    .wdata                   (j_wdata),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  assign cmd_done = (state == ST_JRESP);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      last_jtag <= 1'b0;
    end else begin
      state     <= state_nx;
      last_jtag <= last_jtag_nx;
    end
  end

  // Next state. JTAG normally wins in IDLE, except directly after a JTAG
  // grant with the CPU waiting, so neither side waits more than one foreign
  // access.
  always_comb begin
    state_nx     = state;
    last_jtag_nx = last_jtag;
    unique case (state)
      ST_IDLE: begin
        if (j_pending && !(last_jtag && cpu_req)) begin
          state_nx     = ST_JGRANT;
          last_jtag_nx = 1'b1;
        end else if (cpu_req) begin
          state_nx     = ST_CGRANT;
          last_jtag_nx = 1'b0;
        end
      end
      ST_JGRANT: state_nx = ST_JRESP;
      ST_JRESP:  state_nx = ST_IDLE;
      ST_CGRANT: state_nx = ST_CRESP;
      ST_CRESP:  state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // RAM port and CPU response decode straight from state, so an
  // asynchronous reset drops them in the same instant.
  always_comb begin
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    cpu_waitrequest = 1'b1;
    cpu_rdata       = '0;
    unique case (state)
      ST_JGRANT: begin
        ram_en    = 1'b1;
        ram_we    = (j_cmd == JCMD_WRITE);
        ram_addr  = j_addr;
        ram_wdata = j_wdata;
      end
      ST_CGRANT: begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      ST_CRESP: begin
        cpu_waitrequest = 1'b0;
        cpu_rdata       = ram_rdata;
      end
      default: begin
        ram_en = 1'b0;
      end
    endcase
  end

  // RAM data is valid during JRESP (one cycle after the JGRANT strobe).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg <= '0;
    end else if (state == ST_JRESP && j_cmd == JCMD_READ) begin
      MonDReg <= ram_rdata;
    end
  end

endmodule
